// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: reads sources from the register file, bypasses the
// writeback port, tracks in-flight destinations in a scoreboard and stalls decode on RAW/WAW.
module operand_fetch #(
   parameter int ADDR_WIDTH     = 5,
   parameter int REG_FILE_WIDTH = 32,
   parameter int REG_FILE_NREG  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      dec_valid,
   output logic                      dec_ready,
   input  logic [ADDR_WIDTH-1:0]     dec_addr_a,
   input  logic [ADDR_WIDTH-1:0]     dec_addr_b,
   input  logic                      dec_use_a,
   input  logic                      dec_use_b,
   input  logic [ADDR_WIDTH-1:0]     dec_addr_d,
   input  logic                      dec_wr_en,
   output logic [ADDR_WIDTH-1:0]     rf_addr_a,
   output logic [ADDR_WIDTH-1:0]     rf_addr_b,
   input  logic [REG_FILE_WIDTH-1:0] rf_data_a,
   input  logic [REG_FILE_WIDTH-1:0] rf_data_b,
   input  logic                      wb_valid,
   input  logic [ADDR_WIDTH-1:0]     wb_addr,
   input  logic [REG_FILE_WIDTH-1:0] wb_data,
   output logic                      ex_valid,
   input  logic                      ex_ready,
   output logic [REG_FILE_WIDTH-1:0] ex_op_a,
   output logic [REG_FILE_WIDTH-1:0] ex_op_b,
   output logic [ADDR_WIDTH-1:0]     ex_addr_d,
   output logic                      ex_wr_en,
   output logic [REG_FILE_NREG-1:0]  sb_pending
);

   logic [REG_FILE_NREG-1:0] pending;
   logic [REG_FILE_NREG-1:0] pending_nxt;
   logic wb_hit_a, wb_hit_b, wb_hit_d;
   logic haz_a, haz_b, haz_d;
   logic stall, accept;

   assign rf_addr_a  = dec_addr_a;
   assign rf_addr_b  = dec_addr_b;
   assign sb_pending = pending;

   // A writeback landing this cycle resolves the hazard on that register (bypass).
   assign wb_hit_a = wb_valid && (wb_addr == dec_addr_a);
   assign wb_hit_b = wb_valid && (wb_addr == dec_addr_b);
   assign wb_hit_d = wb_valid && (wb_addr == dec_addr_d);

   assign haz_a = dec_use_a && pending[dec_addr_a] && !wb_hit_a;
   assign haz_b = dec_use_b && pending[dec_addr_b] && !wb_hit_b;
   assign haz_d = dec_wr_en && pending[dec_addr_d] && !wb_hit_d;
   assign stall = haz_a || haz_b || haz_d;

   // Handshake: a transfer happens on a posedge where valid && ready; ready never
   // depends on valid, and a producer holds its payload stable until the transfer.
   assign dec_ready = !rst && !stall && (!ex_valid || ex_ready);
   assign accept    = dec_valid && dec_ready;

   // Clear for the writeback first, then set for the new destination so set wins.
   always_comb begin
      pending_nxt = pending;
      if (wb_valid)
         pending_nxt[wb_addr] = 1'b0;
      if (accept && dec_wr_en)
         pending_nxt[dec_addr_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid  <= 1'b0;
         ex_op_a   <= '0;
         ex_op_b   <= '0;
         ex_addr_d <= '0;
         ex_wr_en  <= 1'b0;
      end else if (accept) begin
         ex_valid  <= 1'b1;
         ex_op_a   <= wb_hit_a ? wb_data : rf_data_a;
         ex_op_b   <= wb_hit_b ? wb_data : rf_data_b;
         ex_addr_d <= dec_addr_d;
         ex_wr_en  <= dec_wr_en;
      end else if (ex_ready) begin
         ex_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a small register file model feeds rf_data_*,
// each scenario task drives decode/writeback and checks outputs inline.
module tb_operand_fetch;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          dec_valid, dec_ready;
   logic [AW-1:0] dec_addr_a, dec_addr_b, dec_addr_d;
   logic          dec_use_a, dec_use_b, dec_wr_en;
   logic [AW-1:0] rf_addr_a, rf_addr_b;
   logic [DW-1:0] rf_data_a, rf_data_b;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          ex_valid, ex_ready, ex_wr_en;
   logic [DW-1:0] ex_op_a, ex_op_b;
   logic [AW-1:0] ex_addr_d;
   logic [NR-1:0] sb_pending;

   logic [DW-1:0] rf [NR];
   int n_pass  = 0;
   int n_total = 0;

   operand_fetch #(.ADDR_WIDTH(AW), .REG_FILE_WIDTH(DW), .REG_FILE_NREG(NR)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_addr_a(dec_addr_a), .dec_addr_b(dec_addr_b),
      .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
      .dec_addr_d(dec_addr_d), .dec_wr_en(dec_wr_en),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
      .ex_addr_d(ex_addr_d), .ex_wr_en(ex_wr_en),
      .sb_pending(sb_pending)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // register file model: preloaded on reset, written by the writeback port
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) rf[i] <= 32'h1000 + i;
         rf[1] <= 32'd5;
         rf[2] <= 32'd7;
      end else if (wb_valid) begin
         rf[wb_addr] <= wb_data;
      end
   end
   assign rf_data_a = rf[rf_addr_a];
   assign rf_data_b = rf[rf_addr_b];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_dec(input logic v, input logic [AW-1:0] a, input logic ua,
                            input logic [AW-1:0] b, input logic ub,
                            input logic [AW-1:0] d, input logic we);
      dec_valid = v; dec_addr_a = a; dec_use_a = ua;
      dec_addr_b = b; dec_use_b = ub; dec_addr_d = d; dec_wr_en = we;
      #1;
   endtask

   task automatic drive_wb(input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      wb_valid = v; wb_addr = addr; wb_data = data;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ex_ready = 1'b1;
      drive_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      drive_wb(1'b0, 0, 0);
      tick(); tick();
      n_total++; if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid: got %b expected 0", ex_valid); else n_pass++;
      n_total++; if (ex_op_a !== 32'h0 || ex_op_b !== 32'h0) $display("FAIL rst_ops: got %h/%h expected 0/0", ex_op_a, ex_op_b); else n_pass++;
      n_total++; if (ex_addr_d !== 5'd0 || ex_wr_en !== 1'b0) $display("FAIL rst_dest: got %0d/%b expected 0/0", ex_addr_d, ex_wr_en); else n_pass++;
      n_total++; if (sb_pending !== 32'h0) $display("FAIL rst_sb: got %h expected 0", sb_pending); else n_pass++;
      n_total++; if (dec_ready !== 1'b0) $display("FAIL rst_dec_ready: got %b expected 0", dec_ready); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (dec_ready !== 1'b1) $display("FAIL post_rst_ready: got %b expected 1", dec_ready); else n_pass++;
   endtask

   task automatic test_back_to_back();
      drive_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
      n_total++; if (rf_addr_a !== 5'd1 || rf_addr_b !== 5'd2) $display("FAIL b2b_rf_addr: got %0d/%0d expected 1/2", rf_addr_a, rf_addr_b); else n_pass++;
      tick();
      n_total++; if (ex_valid !== 1'b1 || ex_op_a !== 32'd5 || ex_op_b !== 32'd7) $display("FAIL b2b_first: got v=%b %h/%h expected 1 5/7", ex_valid, ex_op_a, ex_op_b); else n_pass++;
      n_total++; if (ex_addr_d !== 5'd3 || ex_wr_en !== 1'b1) $display("FAIL b2b_first_dest: got %0d/%b expected 3/1", ex_addr_d, ex_wr_en); else n_pass++;
      drive_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1);
      n_total++; if (dec_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", dec_ready); else n_pass++;
      tick();
      n_total++; if (ex_op_a !== 32'd5 || ex_op_b !== 32'd7 || ex_addr_d !== 5'd4) $display("FAIL b2b_second: got %h/%h d=%0d expected 5/7 d=4", ex_op_a, ex_op_b, ex_addr_d); else n_pass++;
      n_total++; if (sb_pending !== 32'h18) $display("FAIL b2b_sb: got %h expected 18", sb_pending); else n_pass++;
      drive_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      tick();
      n_total++; if (ex_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", ex_valid); else n_pass++;
      drive_wb(1'b1, 5'd3, 32'h33); tick();
      drive_wb(1'b1, 5'd4, 32'h44); tick();
      drive_wb(1'b0, 0, 0);
      n_total++; if (sb_pending !== 32'h0) $display("FAIL b2b_sb_clear: got %h expected 0", sb_pending); else n_pass++;
   endtask

   task automatic test_raw_bypass();
      drive_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
      tick();
      drive_dec(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_total++; if (dec_ready !== 1'b0) $display("FAIL raw_stall%0d: got %b expected 0", i, dec_ready); else n_pass++;
         tick();
      end
      n_total++; if (ex_valid !== 1'b0) $display("FAIL raw_bubble: got %b expected 0", ex_valid); else n_pass++;
      drive_wb(1'b1, 5'd3, 32'hDEAD);
      n_total++; if (dec_ready !== 1'b1) $display("FAIL raw_release: got %b expected 1", dec_ready); else n_pass++;
      tick();
      drive_wb(1'b0, 0, 0);
      drive_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      n_total++; if (ex_op_a !== 32'hDEAD || ex_op_b !== 32'd5) $display("FAIL raw_bypass: got %h/%h expected dead/5", ex_op_a, ex_op_b); else n_pass++;
      n_total++; if (ex_addr_d !== 5'd6 || ex_valid !== 1'b1) $display("FAIL raw_dest: got d=%0d v=%b expected 6/1", ex_addr_d, ex_valid); else n_pass++;
      n_total++; if (sb_pending !== 32'h40) $display("FAIL raw_sb: got %h expected 40", sb_pending); else n_pass++;
      drive_wb(1'b1, 5'd6, 32'h66); tick();
      drive_wb(1'b0, 0, 0);
      n_total++; if (sb_pending !== 32'h0) $display("FAIL raw_sb_clear: got %h expected 0", sb_pending); else n_pass++;
   endtask

   task automatic test_waw();
      drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      tick();
      n_total++; if (sb_pending !== 32'h20) $display("FAIL waw_sb_set: got %h expected 20", sb_pending); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_total++; if (dec_ready !== 1'b0) $display("FAIL waw_stall%0d: got %b expected 0", i, dec_ready); else n_pass++;
         tick();
      end
      drive_wb(1'b1, 5'd5, 32'h55);
      n_total++; if (dec_ready !== 1'b1) $display("FAIL waw_release: got %b expected 1", dec_ready); else n_pass++;
      tick();
      drive_wb(1'b0, 0, 0);
      drive_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      n_total++; if (ex_valid !== 1'b1 || ex_addr_d !== 5'd5) $display("FAIL waw_issue: got v=%b d=%0d expected 1/5", ex_valid, ex_addr_d); else n_pass++;
      n_total++; if (sb_pending !== 32'h20) $display("FAIL waw_set_wins: got %h expected 20", sb_pending); else n_pass++;
      drive_wb(1'b1, 5'd5, 32'h56); tick();
      // writeback to a register that is not pending leaves the scoreboard alone
      drive_wb(1'b1, 5'd12, 32'hC0); tick();
      drive_wb(1'b0, 0, 0);
      n_total++; if (sb_pending !== 32'h0) $display("FAIL waw_sb_clear: got %h expected 0", sb_pending); else n_pass++;
   endtask

   task automatic test_backpressure();
      ex_ready = 1'b0;
      drive_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
      tick();
      drive_dec(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1);
      for (int i = 0; i < 4; i++) begin
         n_total++; if (dec_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b expected 0", i, dec_ready); else n_pass++;
         n_total++; if (ex_valid !== 1'b1 || ex_op_a !== 32'd5 || ex_op_b !== 32'd7 || ex_addr_d !== 5'd7)
            $display("FAIL bp_hold%0d: got v=%b %h/%h d=%0d expected 1 5/7 d=7", i, ex_valid, ex_op_a, ex_op_b, ex_addr_d);
         else n_pass++;
         tick();
      end
      ex_ready = 1'b1;
      #1;
      n_total++; if (dec_ready !== 1'b1) $display("FAIL bp_release: got %b expected 1", dec_ready); else n_pass++;
      tick();
      drive_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      n_total++; if (ex_op_a !== 32'd7 || ex_op_b !== 32'd5 || ex_addr_d !== 5'd8) $display("FAIL bp_next: got %h/%h d=%0d expected 7/5 d=8", ex_op_a, ex_op_b, ex_addr_d); else n_pass++;
      n_total++; if (sb_pending !== 32'h180) $display("FAIL bp_sb: got %h expected 180", sb_pending); else n_pass++;
      drive_wb(1'b1, 5'd7, 32'h77); tick();
      drive_wb(1'b1, 5'd8, 32'h88); tick();
      drive_wb(1'b0, 0, 0);
   endtask

   task automatic test_unused_source();
      drive_dec(1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 5'd9, 1'b1);
      tick();
      drive_dec(1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1);
      n_total++; if (dec_ready !== 1'b0) $display("FAIL unused_used_b_stalls: got %b expected 0", dec_ready); else n_pass++;
      drive_dec(1'b1, 5'd1, 1'b1, 5'd9, 1'b0, 5'd10, 1'b1);
      n_total++; if (dec_ready !== 1'b1) $display("FAIL unused_no_stall: got %b expected 1", dec_ready); else n_pass++;
      tick();
      drive_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      n_total++; if (ex_addr_d !== 5'd10 || ex_op_a !== 32'd5) $display("FAIL unused_issue: got d=%0d a=%h expected 10/5", ex_addr_d, ex_op_a); else n_pass++;
      n_total++; if (sb_pending !== 32'h600) $display("FAIL unused_sb: got %h expected 600", sb_pending); else n_pass++;
   endtask

   task automatic test_reset_mid_stall();
      drive_dec(1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1);
      n_total++; if (dec_ready !== 1'b0) $display("FAIL rms_stall: got %b expected 0", dec_ready); else n_pass++;
      tick();
      rst = 1'b1;
      #1;
      n_total++; if (dec_ready !== 1'b0) $display("FAIL rms_ready_in_rst: got %b expected 0", dec_ready); else n_pass++;
      tick();
      rst = 1'b0;
      #1;
      n_total++; if (ex_valid !== 1'b0 || sb_pending !== 32'h0) $display("FAIL rms_cleared: got v=%b sb=%h expected 0/0", ex_valid, sb_pending); else n_pass++;
      n_total++; if (dec_ready !== 1'b1) $display("FAIL rms_ready_after: got %b expected 1", dec_ready); else n_pass++;
      tick();
      drive_dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      n_total++; if (ex_valid !== 1'b1 || ex_addr_d !== 5'd11 || ex_op_a !== 32'h1009 || ex_op_b !== 32'd7)
         $display("FAIL rms_issue: got v=%b d=%0d %h/%h expected 1 d=11 1009/7", ex_valid, ex_addr_d, ex_op_a, ex_op_b);
      else n_pass++;
      n_total++; if (sb_pending !== 32'h800) $display("FAIL rms_sb: got %h expected 800", sb_pending); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_raw_bypass();
      test_waw();
      test_backpressure();
      test_unused_source();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue stage between decode and execute. Accepts one decoded instruction per cycle, drives the register file read addresses, and captures operands into a pipeline register for execute. A per-register scoreboard tracks in-flight writes and stalls decode on RAW/WAW hazards. Operands are bypassed from the writeback port in the cycle the register file is being written.

## Interface
- ADDR_WIDTH, 5, register address width
- REG_FILE_WIDTH, 32, data width
- REG_FILE_NREG, 32, number of registers; scoreboard width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage accepts this cycle
- dec_addr_a / dec_addr_b  in  ADDR_WIDTH  source registers
- dec_use_a / dec_use_b  in  1  source actually read (hazard check enable)
- dec_addr_d  in  ADDR_WIDTH  destination register
- dec_wr_en  in  1  instruction writes dec_addr_d
- rf_addr_a / rf_addr_b  out  ADDR_WIDTH  to register file addrA/addrB
- rf_data_a / rf_data_b  in  REG_FILE_WIDTH  from register file data_a/data_b
- wb_valid  in  1  writeback this cycle (same signal drives register file wrt)
- wb_addr  in  ADDR_WIDTH  writeback register
- wb_data  in  REG_FILE_WIDTH  writeback data
- ex_valid  out  1  operand register holds a valid instruction
- ex_ready  in  1  execute consumes it
- ex_op_a / ex_op_b  out  REG_FILE_WIDTH  captured operands
- ex_addr_d  out  ADDR_WIDTH; ex_wr_en  out  1  forwarded destination
- sb_pending  out  REG_FILE_NREG  scoreboard bits (debug)

## Operation
- rf_addr_a = dec_addr_a, rf_addr_b = dec_addr_b, combinational, always driven.
- Hazard per source X in {a,b}: haz_X = dec_use_X & pending[dec_addr_X] & !(wb_valid & wb_addr==dec_addr_X).
- WAW: haz_d = dec_wr_en & pending[dec_addr_d] & !(wb_valid & wb_addr==dec_addr_d).
- stall = haz_a | haz_b | haz_d. dec_ready = !stall & (!ex_valid | ex_ready). Combinational; dec_ready may be high while dec_valid is low.
- Accept = dec_valid & dec_ready. On accept, the operand register loads:
  - op_X = wb_data if wb_valid & wb_addr==dec_addr_X, else rf_data_X.
  - addr_d and wr_en are copied; ex_valid is set to 1.
- No accept and ex_ready: ex_valid is cleared. No accept and !ex_ready: the operand register holds.
- Scoreboard update each posedge, in priority order:
  - Clear pending[wb_addr] if wb_valid.
  - Then set pending[dec_addr_d] if accept & dec_wr_en. On the same address, set wins.
- Register 0 is an ordinary register; it is not hardwired.
- A writeback to a non-pending register is legal. It is bypassed and the scoreboard is unchanged.
- One outstanding write per register is guaranteed by the WAW stall.

## Timing
- Reset, synchronous: ex_valid=0, ex_op_a=ex_op_b=0, ex_addr_d=0, ex_wr_en=0, sb_pending=0.
  - While rst is high, dec_ready=0 and no scoreboard update happens.
  - Reset mid-stall or mid-hold discards the held instruction.
- Latency: an instruction accepted at edge N is presented on ex_* from edge N until consumed. Issue-to-execute latency is 1 cycle.
- The register file samples addresses at negedge, so rf_data_* is valid before the following posedge. The stage samples rf_data_* only at the accept edge.
- Throughput: 1 instruction/cycle with no hazards and ex_ready held high.
- Stall release: a source pending on rX issues in the same cycle wb_valid & wb_addr==rX (via bypass), not one cycle later.
- Backpressure: with ex_valid=1 and ex_ready=0, the ex_* outputs stay stable and dec_ready=0.

## Test plan
- Reset then back-to-back independent ops:
  - Stimulus: registers preloaded r1=5, r2=7. Issue A: r3←r1,r2. Issue B: r4←r1,r2.
  - Required: ex_op_a=5, ex_op_b=7 on consecutive cycles; sb_pending=0x18.
- RAW stall and bypass:
  - Stimulus: issue A: r3←r1,r2; then B reading r3. Hold wb off for 3 cycles, then wb r3=0xDEAD.
  - Required: dec_ready=0 for those 3 cycles; B issues in the wb cycle with ex_op_a=0xDEAD; pending[3] clears.
- WAW:
  - Stimulus: r5 pending; decode offers a write to r5 with no sources used.
  - Required: stall until wb r5; in that cycle, accept and pending[5] stays 1 (set wins).
- Backpressure:
  - Stimulus: ex_ready=0 for 4 cycles with dec_valid high.
  - Required: ex_* stable, dec_ready=0; with ex_ready=1 the next instruction is accepted on that edge.
- Unused-source pending:
  - Stimulus: dec_use_b=0 with dec_addr_b pending.
  - Required: no stall.
- Synchronous reset mid-stall:
  - Stimulus: rst=1 for 1 cycle during a stall.
  - Required: ex_valid=0, sb_pending=0 next cycle; the stalled instruction issues immediately after reset deasserts.
